// File: rtl/dcache_wbuf_if.sv
// Core/dcache side bundle of the store buffer: core load/store port, dcache port
// and buffer occupancy status.
interface dcache_wbuf_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          memwrite;
  logic          memread;
  logic [AW-1:0] dataaddr;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [DW-1:0] dc_rdata;
  logic [CW-1:0] wb_count;
  logic          wb_empty;

  modport slave (
    input  memwrite, memread, dataaddr, writedata, dc_rdata,
    output readdata, dc_we, dc_addr, dc_wdata, wb_count, wb_empty
  );

  modport master (
    output memwrite, memread, dataaddr, writedata, dc_rdata,
    input  readdata, dc_we, dc_addr, dc_wdata, wb_count, wb_empty
  );
endinterface

// File: rtl/dcache_wbuf.sv
// Store buffer between the core data port and a single-ported dcache: a circular
// FIFO of {addr, data} that drains on non-load cycles and forwards to loads.
module dcache_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  dcache_wbuf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_drain;
  logic             w_store;
  logic             w_push;
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_coal;
  logic [DW-1:0]    w_fwd;

  // Loads own the dcache port; a simultaneous store is dropped.
  assign w_drain = !bus.memread && (r_count != '0);
  assign w_store = bus.memwrite && !bus.memread;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_hit[gi]  = r_valid[gi] && (r_addr[gi] == bus.dataaddr);
      // The head leaving this cycle must not absorb a newer store, or its old value is lost.
      assign w_coal[gi] = w_hit[gi] && !(w_drain && (r_head == PW'(gi)));
    end
  endgenerate

  assign w_push = w_store && (w_coal == '0);

  always_comb begin
    w_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_hit[i]) begin
        w_fwd = w_fwd | r_data[i];
      end
    end
  end

  assign bus.readdata = (bus.memread && (w_hit != '0)) ? w_fwd : bus.dc_rdata;
  assign bus.dc_we    = w_drain;
  assign bus.dc_addr  = w_drain ? r_addr[r_head] : bus.dataaddr;
  assign bus.dc_wdata = r_data[r_head];
  assign bus.wb_count = r_count;
  assign bus.wb_empty = (r_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_store && w_coal[i]) begin
          r_data[i] <= bus.writedata;
        end
      end
      // Placed after the pop so a full-buffer store reusing the head slot stays valid.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= bus.dataaddr;
        r_data[r_tail]  <= bus.writedata;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_drain);
    end
  end

  a_no_rw_collision: assert property (@(posedge clk) disable iff (reset)
                                      !(bus.memread && bus.memwrite));
endmodule

// File: tb/tb_dcache_wbuf.sv
// Randomized scoreboard bench for dcache_wbuf: a queue-based store-buffer model
// predicts dcache writes, load data and occupancy; a negedge monitor checks them.
module tb_dcache_wbuf;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_wbuf_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  dcache_wbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] dmem    [256];
  logic [DW-1:0] ref_mem [256];

  assign bus.dc_rdata = dmem[bus.dc_addr];
  always @(posedge clk) if (bus.dc_we) dmem[bus.dc_addr] <= bus.dc_wdata;

  ent_t          model_q [$];
  ent_t          wr_q    [$];
  logic [DW-1:0] rd_q    [$];
  int            cnt_q   [$];
  int  total  = 0;
  int  bad    = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: checks whatever the DUT presents this cycle against queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cnt_q.size() > 0) begin
        int c;
        c = cnt_q.pop_front();
        chk("wb_count", 32'(bus.wb_count), 32'(c));
        chk("wb_empty", 32'(bus.wb_empty), 32'(c == 0));
      end
      if (bus.dc_we) begin
        if (wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dc_write_unexpected got=addr %h data %h exp=none", bus.dc_addr, bus.dc_wdata);
        end else begin
          ent_t e;
          e = wr_q.pop_front();
          chk("dc_addr", 32'(bus.dc_addr), 32'(e.addr));
          chk("dc_wdata", bus.dc_wdata, e.data);
        end
      end
      if (bus.memread && rd_q.size() > 0) begin
        chk("readdata", bus.readdata, rd_q.pop_front());
      end
    end
  end

  // One core cycle: drive inputs, record model expectations, advance past the edge.
  task automatic cycle(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit found;
    bus.memread   = rd;
    bus.memwrite  = wr;
    bus.dataaddr  = a;
    bus.writedata = d;
    cnt_q.push_back(model_q.size());
    if (rd) begin
      logic [DW-1:0] exp;
      exp = ref_mem[a];
      foreach (model_q[k]) if (model_q[k].addr == a) exp = model_q[k].data;
      rd_q.push_back(exp);
    end else if (model_q.size() > 0) begin
      ent_t e;
      e = model_q.pop_front();
      wr_q.push_back(e);
      ref_mem[e.addr] = e.data;
    end
    if (wr && !rd) begin
      found = 1'b0;
      foreach (model_q[k]) begin
        if (model_q[k].addr == a) begin
          model_q[k].data = d;
          found = 1'b1;
        end
      end
      if (!found) model_q.push_back('{addr: a, data: d});
    end
    $display("txn rd=%0b wr=%0b addr=%h data=%h buffered=%0d", rd, wr, a, d, model_q.size());
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      dmem[i]    = ref_mem[i];
    end
    bus.memread   = 1'b1;
    bus.memwrite  = 1'b0;
    bus.dataaddr  = 8'h10;
    bus.writedata = '0;
    #3;
    chk("reset_wb_count", 32'(bus.wb_count), 32'd0);
    chk("reset_wb_empty", 32'(bus.wb_empty), 32'd1);
    chk("reset_dc_we", 32'(bus.dc_we), 32'd0);
    chk("reset_dc_addr", 32'(bus.dc_addr), 32'h10);
    chk("reset_readdata", bus.readdata, ref_mem[8'h10]);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    cycle(1'b1, 1'b0, 8'h10, '0);
    // Store then forwarded load, then drain on the idle cycle.
    cycle(1'b0, 1'b1, 8'h05, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 8'h05, '0);
    cycle(1'b0, 1'b0, 8'h00, '0);
    cycle(1'b1, 1'b0, 8'h05, '0);
    // Store hitting the draining head must append behind it.
    cycle(1'b0, 1'b1, 8'h07, 32'h1);
    cycle(1'b1, 1'b0, 8'h07, '0);
    cycle(1'b0, 1'b1, 8'h07, 32'h2);
    cycle(1'b1, 1'b0, 8'h07, '0);
    cycle(1'b0, 1'b0, 8'h00, '0);
    cycle(1'b1, 1'b0, 8'h07, '0);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 2);
      cycle(r == 1, r == 2, 8'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset mid-cycle while the buffer is about to drain.
    cycle(1'b0, 1'b1, 8'h20, 32'h12345678);
    cycle(1'b1, 1'b0, 8'h21, '0);
    #2;
    mon_en       = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_wb_count", 32'(bus.wb_count), 32'd0);
    chk("async_reset_dc_we", 32'(bus.dc_we), 32'd0);
    model_q.delete();
    wr_q.delete();
    rd_q.delete();
    cnt_q.delete();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int n = 0; n < 6; n++) cycle(1'b0, 1'b0, 8'h20, '0);
    cycle(1'b1, 1'b0, 8'h20, '0);

    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 2);
      cycle(r == 1, r == 2, 8'($urandom_range(0, 7)), $urandom);
    end
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 8'h00, '0);

    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_reads", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
